// File: rtl/bus_dest_load.sv
// bus_dest_load: destination side of the common bus (AR/PC/DR/AC/IR and RAM write port).
// Optional sticky illegal-command flag enabled by defining BUS_DEST_ERR_EN.
module bus_dest_load #(
    parameter int N  = 16,
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  bus_in,
    input  logic [2:0]    DDD,
    input  logic [1:0]    op,
    input  logic          mem_ack,
    output logic [AW-1:0] AR,
    output logic [AW-1:0] PC,
    output logic [N-1:0]  DR,
    output logic [N-1:0]  AC,
    output logic [N-1:0]  IR,
    output logic [AW-1:0] mem_addr,
    output logic [N-1:0]  mem_wdata,
    output logic          mem_we,
    output logic          busy,
    output logic          err
);
    typedef enum logic {IDLE, WR_WAIT} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] ar_q, ar_d, pc_q, pc_d, maddr_q, maddr_d;
    logic [N-1:0]  dr_q, dr_d, ac_q, ac_d, ir_q, ir_d, mdata_q, mdata_d;
    logic          we_q, we_d;

    function automatic logic [AW-1:0] upd_a(input logic [AW-1:0] v, input logic [1:0] o,
                                            input logic [AW-1:0] b);
        return o == 2'b01 ? b : o == 2'b10 ? v + AW'(1) : o == 2'b11 ? '0 : v;
    endfunction

    function automatic logic [N-1:0] upd_n(input logic [N-1:0] v, input logic [1:0] o,
                                           input logic [N-1:0] b);
        return o == 2'b01 ? b : o == 2'b10 ? v + N'(1) : o == 2'b11 ? '0 : v;
    endfunction

    wire idle = (state_q == IDLE);

    always_comb begin
        ar_d    = ar_q;
        pc_d    = pc_q;
        dr_d    = dr_q;
        ac_d    = ac_q;
        ir_d    = ir_q;
        maddr_d = maddr_q;
        mdata_d = mdata_q;
        we_d    = we_q;
        state_d = state_q;
        if (idle) begin
            case (DDD)
                3'd1: ar_d = upd_a(ar_q, op, bus_in[AW-1:0]);
                3'd2: pc_d = upd_a(pc_q, op, bus_in[AW-1:0]);
                3'd3: dr_d = upd_n(dr_q, op, bus_in);
                3'd4: ac_d = upd_n(ac_q, op, bus_in);
                3'd5: ir_d = (op == 2'b10) ? ir_q : upd_n(ir_q, op, bus_in);
                3'd7: if (op == 2'b01) begin
                    maddr_d = ar_q;
                    mdata_d = bus_in;
                    we_d    = 1'b1;
                    state_d = WR_WAIT;
                end
                default: ;
            endcase
        end else if (mem_ack) begin
            we_d    = 1'b0;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ar_q    <= '0;
            pc_q    <= '0;
            dr_q    <= '0;
            ac_q    <= '0;
            ir_q    <= '0;
            maddr_q <= '0;
            mdata_q <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ar_q    <= ar_d;
            pc_q    <= pc_d;
            dr_q    <= dr_d;
            ac_q    <= ac_d;
            ir_q    <= ir_d;
            maddr_q <= maddr_d;
            mdata_q <= mdata_d;
            we_q    <= we_d;
        end
    end

`ifdef BUS_DEST_ERR_EN
    logic err_q, err_d;
    logic illegal;

    // Commands that decode to no legal action: empty codes, RAM inc/clear, IR increment.
    always_comb begin
        illegal = (op != 2'b00) && ((DDD == 3'd0) || (DDD == 3'd6) ||
                  (DDD == 3'd7 && op != 2'b01) || (DDD == 3'd5 && op == 2'b10));
        err_d   = err_q | (idle & illegal);
    end

    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign AR        = ar_q;
    assign PC        = pc_q;
    assign DR        = dr_q;
    assign AC        = ac_q;
    assign IR        = ir_q;
    assign mem_addr  = maddr_q;
    assign mem_wdata = mdata_q;
    assign mem_we    = we_q;
    // busy and mem_we share one flop: both rise on request and fall on ack.
    assign busy      = we_q;
endmodule

// File: tb/tb_bus_dest_load.sv
// tb_bus_dest_load: scoreboard bench for bus_dest_load; expected state queued per driven cycle.
module tb_bus_dest_load;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] bus_in = '0;
    logic [2:0]  DDD = '0;
    logic [1:0]  op = '0;
    logic        mem_ack = 1'b0;
    logic [11:0] AR, PC, mem_addr;
    logic [15:0] DR, AC, IR, mem_wdata;
    logic        mem_we, busy, err;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [11:0] ar, pc, ma;
        logic [15:0] dr, ac, ir, md;
        logic        we, busy, err;
    } st_t;

    st_t m = '0;
    st_t q[$];

    bus_dest_load #(.N(16), .AW(12)) dut (
        .clk(clk), .rst(rst), .bus_in(bus_in), .DDD(DDD), .op(op), .mem_ack(mem_ack),
        .AR(AR), .PC(PC), .DR(DR), .AC(AC), .IR(IR),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] nv(input logic [15:0] v, input logic [1:0] o,
                                       input logic [15:0] b, input int w);
        logic [15:0] mask;
        mask = (w == 16) ? 16'hFFFF : 16'h0FFF;
        case (o)
            2'b01:   return b & mask;
            2'b10:   return (v + 16'd1) & mask;
            2'b11:   return 16'h0000;
            default: return v;
        endcase
    endfunction

    task automatic step(input logic r, input logic [2:0] d, input logic [1:0] o,
                        input logic [15:0] b, input logic a);
        st_t e, g;
        e = m;
        if (r) e = '0;
        else if (!m.busy) begin
            if (d == 3'd1) e.ar = 12'(nv({4'h0, m.ar}, o, b, 12));
            if (d == 3'd2) e.pc = 12'(nv({4'h0, m.pc}, o, b, 12));
            if (d == 3'd3) e.dr = nv(m.dr, o, b, 16);
            if (d == 3'd4) e.ac = nv(m.ac, o, b, 16);
            if (d == 3'd5 && o != 2'b10) e.ir = nv(m.ir, o, b, 16);
            if (d == 3'd7 && o == 2'b01) begin
                e.ma = m.ar; e.md = b; e.we = 1'b1; e.busy = 1'b1;
            end
`ifdef BUS_DEST_ERR_EN
            if (o != 2'b00 && (d == 3'd0 || d == 3'd6 || (d == 3'd7 && o != 2'b01) ||
                (d == 3'd5 && o == 2'b10))) e.err = 1'b1;
`endif
        end else if (a) begin
            e.we = 1'b0; e.busy = 1'b0;
        end
        q.push_back(e);
        m = e;
        rst = r; DDD = d; op = o; bus_in = b; mem_ack = a;
        @(posedge clk);
        #1;
        g = q.pop_front();
        check("AR", {20'h0, AR}, {20'h0, g.ar});
        check("PC", {20'h0, PC}, {20'h0, g.pc});
        check("DR", {16'h0, DR}, {16'h0, g.dr});
        check("AC", {16'h0, AC}, {16'h0, g.ac});
        check("IR", {16'h0, IR}, {16'h0, g.ir});
        check("mem_addr", {20'h0, mem_addr}, {20'h0, g.ma});
        check("mem_wdata", {16'h0, mem_wdata}, {16'h0, g.md});
        check("mem_we", {31'h0, mem_we}, {31'h0, g.we});
        check("busy", {31'h0, busy}, {31'h0, g.busy});
        check("err", {31'h0, err}, {31'h0, g.err});
    endtask

    initial begin
        step(1, 0, 0, 16'h0000, 0);
        step(0, 1, 1, 16'h0ABC, 0);
        check("ar_load", {20'h0, AR}, 32'h0ABC);
        step(0, 2, 1, 16'hFFFF, 0);
        step(0, 2, 2, 16'h0000, 0);
        check("pc_wrap", {20'h0, PC}, 32'h0);
        step(0, 4, 1, 16'hFFFF, 0);
        step(0, 4, 2, 16'h0000, 0);
        check("ac_wrap", {16'h0, AC}, 32'h0);
        step(0, 1, 1, 16'h0010, 0);
        step(0, 7, 1, 16'h1234, 0);
        step(0, 7, 1, 16'h9999, 0);
        step(0, 3, 1, 16'hBEEF, 0);
        check("wr_addr", {20'h0, mem_addr}, 32'h010);
        check("wr_data", {16'h0, mem_wdata}, 32'h1234);
        check("wr_busy", {31'h0, busy}, 32'h1);
        check("dr_frozen", {16'h0, DR}, 32'h0);
        step(0, 0, 0, 16'h0000, 1);
        check("ack_we", {31'h0, mem_we}, 32'h0);
        step(0, 7, 1, 16'hAAAA, 0);
        step(1, 0, 0, 16'h0000, 0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        step(0, 0, 0, 16'h0000, 1);
        step(0, 1, 1, 16'h0FFF, 0);
        step(0, 7, 1, 16'h4321, 1);
        step(0, 0, 0, 16'h0000, 1);
        check("fast_ack", {31'h0, busy}, 32'h0);
        step(0, 1, 2, 16'h0000, 0);
        check("ar_wrap", {20'h0, AR}, 32'h0);
        step(0, 3, 1, 16'h5555, 0);
        step(0, 3, 3, 16'h0000, 0);
        check("dr_clr", {16'h0, DR}, 32'h0);
        step(0, 5, 1, 16'hC0DE, 0);
        step(0, 5, 2, 16'h0000, 0);
        check("ir_noinc", {16'h0, IR}, 32'hC0DE);
        step(0, 7, 2, 16'h1111, 0);
        step(0, 6, 1, 16'h7777, 0);
        step(0, 0, 0, 16'h0000, 0);
        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 63) == 0), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                 16'($urandom), ($urandom_range(0, 2) == 0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
